// File: rtl/hazard_pkg.sv
// Shared types for the forwarding / hazard controller: forward-select codes and FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_match.sv
// Per-source comparator: picks the forward source for one ID operand and flags a load-use hit.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic          used,
  input  logic          valid,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_wren,
  input  logic          ex_is_load,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_wren,
  output fwd_sel_e      sel,
  output logic          load_hit
);

  // EX match wins over MEM: the EX result is the younger write to rs.
  always_comb begin
    sel      = FWD_RF;
    load_hit = 1'b0;
    if (valid && used && (rs != '0)) begin
      if (ex_wren && (rs == ex_rd)) begin
        sel      = FWD_MEM;
        load_hit = ex_is_load;
      end else if (mem_wren && (rs == mem_rd)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ID-stage forwarding decision, load-use bubble and multi-cycle hold controller.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG),
  parameter int NSRC  = 2,
  parameter int CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_valid_i,
  input  logic [NSRC*AW-1:0]  id_rs_addr_i,
  input  logic [NSRC-1:0]     id_rs_used_i,
  input  logic [AW-1:0]       ex_rd_addr_i,
  input  logic                ex_rd_wren_i,
  input  logic                ex_is_load_i,
  input  logic                ex_is_mc_i,
  input  logic                mc_done_i,
  input  logic [AW-1:0]       mem_rd_addr_i,
  input  logic                mem_rd_wren_i,
  input  logic                flush_i,
  output logic [NSRC*2-1:0]   fwd_sel_o,
  output logic                stall_if_o,
  output logic                stall_id_o,
  output logic                stall_ex_o,
  output logic                bubble_ex_o,
  output logic [CNT_W-1:0]    perf_lu_cnt_o,
  output logic [CNT_W-1:0]    perf_mc_cnt_o,
  output logic                dbg_state_o
);

  hz_state_e           state;
  logic [NSRC*2-1:0]   sel_next;
  logic [NSRC-1:0]     load_hit;
  logic                mc_hold;
  logic                lu;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_sel_e sel_k;
    fwd_match #(.AW(AW)) u_match (
      .rs        (id_rs_addr_i[k*AW +: AW]),
      .used      (id_rs_used_i[k]),
      .valid     (id_valid_i),
      .ex_rd     (ex_rd_addr_i),
      .ex_wren   (ex_rd_wren_i),
      .ex_is_load(ex_is_load_i),
      .mem_rd    (mem_rd_addr_i),
      .mem_wren  (mem_rd_wren_i),
      .sel       (sel_k),
      .load_hit  (load_hit[k])
    );
    assign sel_next[k*2 +: 2] = sel_k;
  end

  // The hold covers the entry cycle and every MC_WAIT cycle until the result is ready.
  // Outputs are gated by reset so the pipeline is never stalled while in reset.
  assign mc_hold = rst_ni && !flush_i && !mc_done_i && (ex_is_mc_i || (state == MC_WAIT));
  assign lu      = rst_ni && !flush_i && !mc_hold && (|load_hit);

  assign stall_if_o  = mc_hold || lu;
  assign stall_id_o  = mc_hold || lu;
  assign stall_ex_o  = mc_hold;
  assign bubble_ex_o = lu;
  assign dbg_state_o = (state == MC_WAIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      fwd_sel_o <= '0;
    end else if (flush_i) begin
      state     <= IDLE;
      fwd_sel_o <= '0;
    end else begin
      case (state)
        IDLE:    if (ex_is_mc_i && !mc_done_i) state <= MC_WAIT;
        MC_WAIT: if (mc_done_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      // A bubble entering EX carries no forwarding.
      if (!mc_hold) fwd_sel_o <= lu ? '0 : sel_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mc_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_cnt <= '0;
      mc_cnt <= '0;
    end else begin
      if (lu && (lu_cnt != '1))      lu_cnt <= lu_cnt + CNT_W'(1);
      if (mc_hold && (mc_cnt != '1)) mc_cnt <= mc_cnt + CNT_W'(1);
    end
  end

  assign perf_lu_cnt_o = lu_cnt;
  assign perf_mc_cnt_o = mc_cnt;
`else
  assign perf_lu_cnt_o = '0;
  assign perf_mc_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding, load-use, multi-cycle hold, flush and reset.
module tb_fwd_hazard_ctrl;

  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam int CNT_W = 32;

`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic                clk;
  logic                rst_n;
  logic                id_valid;
  logic [NSRC*AW-1:0]  id_rs_addr;
  logic [NSRC-1:0]     id_rs_used;
  logic [AW-1:0]       ex_rd_addr;
  logic                ex_rd_wren;
  logic                ex_is_load;
  logic                ex_is_mc;
  logic                mc_done;
  logic [AW-1:0]       mem_rd_addr;
  logic                mem_rd_wren;
  logic                flush;
  logic [NSRC*2-1:0]   fwd_sel;
  logic                stall_if;
  logic                stall_id;
  logic                stall_ex;
  logic                bubble_ex;
  logic [CNT_W-1:0]    perf_lu_cnt;
  logic [CNT_W-1:0]    perf_mc_cnt;
  logic                dbg_state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  fwd_hazard_ctrl #(.NREG(32), .AW(AW), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .id_valid_i   (id_valid),
    .id_rs_addr_i (id_rs_addr),
    .id_rs_used_i (id_rs_used),
    .ex_rd_addr_i (ex_rd_addr),
    .ex_rd_wren_i (ex_rd_wren),
    .ex_is_load_i (ex_is_load),
    .ex_is_mc_i   (ex_is_mc),
    .mc_done_i    (mc_done),
    .mem_rd_addr_i(mem_rd_addr),
    .mem_rd_wren_i(mem_rd_wren),
    .flush_i      (flush),
    .fwd_sel_o    (fwd_sel),
    .stall_if_o   (stall_if),
    .stall_id_o   (stall_id),
    .stall_ex_o   (stall_ex),
    .bubble_ex_o  (bubble_ex),
    .perf_lu_cnt_o(perf_lu_cnt),
    .perf_mc_cnt_o(perf_mc_cnt),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    id_valid    = 1'b0;
    id_rs_addr  = '0;
    id_rs_used  = '0;
    ex_rd_addr  = '0;
    ex_rd_wren  = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_mc    = 1'b0;
    mc_done     = 1'b0;
    mem_rd_addr = '0;
    mem_rd_wren = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_id(input logic [AW-1:0] rs1, input logic [AW-1:0] rs0,
                        input logic [1:0] used);
    id_valid   = 1'b1;
    id_rs_addr = {rs1, rs0};
    id_rs_used = used;
  endtask

  task automatic set_ex(input logic [AW-1:0] rd, input logic wren, input logic load);
    ex_rd_addr = rd;
    ex_rd_wren = wren;
    ex_is_load = load;
  endtask

  task automatic set_mem(input logic [AW-1:0] rd, input logic wren);
    mem_rd_addr = rd;
    mem_rd_wren = wren;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stalls(input string tag, input logic s_if, input logic s_id,
                            input logic s_ex, input logic bub);
    chk({tag, "_stall_if"}, 32'(stall_if), 32'(s_if));
    chk({tag, "_stall_id"}, 32'(stall_id), 32'(s_id));
    chk({tag, "_stall_ex"}, 32'(stall_ex), 32'(s_ex));
    chk({tag, "_bubble"},   32'(bubble_ex), 32'(bub));
  endtask

  task automatic chk_sel(input string tag);
    logic [3:0] e;
    e = exp_q.pop_front();
    chk(tag, 32'(fwd_sel), 32'(e));
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk_stalls("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_fwd_sel", 32'(fwd_sel), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);
    chk("reset_perf_lu", perf_lu_cnt, 32'h0);
    chk("reset_perf_mc", perf_mc_cnt, 32'h0);
    #4 rst_n = 1'b1;
    next_cycle();

    // rs1 (source 0) = 5 matches a non-load EX write: forward from MEM next cycle
    set_id(5'd0, 5'd5, 2'b01);
    set_ex(5'd5, 1'b1, 1'b0);
    #1 chk_stalls("ex_fwd", 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0001);
    next_cycle();
    chk_sel("ex_fwd_sel");

    // rs2 (source 1) = 7 matches an EX load: one bubble, then WB forward
    set_id(5'd7, 5'd0, 2'b10);
    set_ex(5'd7, 1'b1, 1'b1);
    #1 chk_stalls("lu", 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(4'b0000);
    next_cycle();
    chk_sel("lu_bubble_sel");
    set_ex(5'd0, 1'b0, 1'b0);
    set_mem(5'd7, 1'b1);
    #1 chk_stalls("lu_after", 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b1000);
    next_cycle();
    chk_sel("lu_wb_sel");
    chk("lu_perf", perf_lu_cnt, 32'(PERF));

    // x0 is never forwarded
    set_id(5'd0, 5'd0, 2'b01);
    set_ex(5'd0, 1'b1, 1'b0);
    set_mem(5'd0, 1'b1);
    #1 chk_stalls("x0", 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    next_cycle();
    chk_sel("x0_sel");

    // EX beats MEM on a double match; source 1 matches EX, source 0 matches MEM
    set_id(5'd3, 5'd3, 2'b01);
    set_ex(5'd3, 1'b1, 1'b0);
    set_mem(5'd3, 1'b1);
    exp_q.push_back(4'b0001);
    next_cycle();
    chk_sel("prio_sel");
    set_id(5'd9, 5'd4, 2'b11);
    set_ex(5'd9, 1'b1, 1'b0);
    set_mem(5'd4, 1'b1);
    exp_q.push_back(4'b0110);
    next_cycle();
    chk_sel("two_src_sel");

    // invalid ID instruction selects the register file
    id_valid = 1'b0;
    exp_q.push_back(4'b0000);
    next_cycle();
    chk_sel("invalid_sel");
    set_id(5'd9, 5'd4, 2'b11);
    exp_q.push_back(4'b0110);
    next_cycle();
    chk_sel("reload_sel");

    // multi-cycle op, result ready in the fifth cycle: exactly four hold cycles
    set_id(5'd0, 5'd5, 2'b01);
    set_ex(5'd5, 1'b1, 1'b0);
    set_mem(5'd0, 1'b0);
    ex_is_mc = 1'b1;
    mc_done  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ex_is_load = (c == 2);
      #1 chk_stalls($sformatf("mc%0d", c), 1'b1, 1'b1, 1'b1, 1'b0);
      exp_q.push_back(4'b0110);
      next_cycle();
      chk_sel($sformatf("mc%0d_sel", c));
      chk($sformatf("mc%0d_state", c), 32'(dbg_state), 32'h1);
    end
    ex_is_load = 1'b0;
    mc_done    = 1'b1;
    #1 chk_stalls("mc_done", 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0001);
    next_cycle();
    chk_sel("mc_done_sel");
    chk("mc_done_state", 32'(dbg_state), 32'h0);
    chk("mc_perf", perf_mc_cnt, 32'(4 * PERF));
    ex_is_mc = 1'b0;
    mc_done  = 1'b0;

    // flush overrides a coincident load-use hazard
    set_id(5'd0, 5'd6, 2'b01);
    set_ex(5'd6, 1'b1, 1'b1);
    flush = 1'b1;
    #1 chk_stalls("flush", 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0000);
    next_cycle();
    chk_sel("flush_sel");
    chk("flush_perf_lu", perf_lu_cnt, 32'(PERF));
    flush = 1'b0;

    // reset asserted while in MC_WAIT
    set_id(5'd0, 5'd2, 2'b01);
    set_ex(5'd2, 1'b1, 1'b0);
    exp_q.push_back(4'b0001);
    next_cycle();
    chk_sel("pre_rst_sel");
    ex_is_mc = 1'b1;
    next_cycle();
    chk("pre_rst_state", 32'(dbg_state), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_stalls("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_sel", 32'(fwd_sel), 32'h0);
    chk("mid_rst_state", 32'(dbg_state), 32'h0);
    chk("mid_rst_perf_lu", perf_lu_cnt, 32'h0);
    chk("mid_rst_perf_mc", perf_mc_cnt, 32'h0);
    clear_inputs();
    #2 rst_n = 1'b1;
    next_cycle();
    chk("post_rst_state", 32'(dbg_state), 32'h0);
    chk_stalls("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the 5-stage RV32I pipeline, successor to the purely combinational EX-stage forwarding unit. It resolves operand sources one stage early: the decision is made in ID, registered, and presented to EX. It also detects load-use hazards and inserts exactly one bubble. A two-state FSM holds the front end while a multi-cycle EX operation runs, and all pending hazard state is cleared on a branch flush.

## Interface
Parameters:
- NREG, 32, architectural register count; register 0 is hard-wired zero.
- AW, $clog2(NREG), register address width.
- NSRC, 2, number of source operands resolved per instruction.
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_addr_i  in  NSRC*AW  ID source addresses; source k is at bits [k*AW +: AW].
- id_rs_used_i  in  NSRC  source k is actually read.
- ex_rd_addr_i  in  AW  EX destination address.
- ex_rd_wren_i  in  1  EX writes rd.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_is_mc_i  in  1  EX instruction is multi-cycle (mul/div class).
- mc_done_i  in  1  multi-cycle result is ready this cycle.
- mem_rd_addr_i  in  AW  MEM destination address.
- mem_rd_wren_i  in  1  MEM writes rd.
- flush_i  in  1  branch mispredict; kill IF/ID.
- fwd_sel_o  out  NSRC*2  registered forward select for EX, one 2-bit field per source.
- stall_if_o  out  1  hold the PC.
- stall_id_o  out  1  hold the IF/ID register.
- stall_ex_o  out  1  hold ID/EX and EX.
- bubble_ex_o  out  1  load a NOP into ID/EX.
- perf_lu_cnt_o  out  CNT_W  load-use stall cycles.
- perf_mc_cnt_o  out  CNT_W  multi-cycle stall cycles.

## Operation
- Forward select encoding per source: 00 register file, 01 MEM result, 10 WB result. 11 is never driven.
- Select rules, evaluated in ID for each source k, in priority order:
  - If the source is unused, id_valid_i=0, or rs=0: select 00.
  - If rs matches ex_rd_addr_i and ex_rd_wren_i=1: select 01. Next cycle that instruction sits in MEM.
  - If rs matches mem_rd_addr_i and mem_rd_wren_i=1: select 10. Next cycle that instruction sits in WB.
  - Otherwise select 00. The register file is write-through, so a match against the current WB stage needs no forward.
- Load-use hazard: an EX match with ex_is_load_i=1.
  - Drives stall_if_o=1, stall_id_o=1, bubble_ex_o=1 for one cycle.
  - The registered select for the bubble is 00.
  - On the following cycle the load is in MEM, and the re-evaluated select for the held instruction is 10.
- FSM states: IDLE and MC_WAIT.
  - IDLE to MC_WAIT when ex_is_mc_i=1 and mc_done_i=0.
  - MC_WAIT to IDLE when mc_done_i=1.
  - In MC_WAIT, and in the entry cycle, stall_if_o, stall_id_o and stall_ex_o are 1, bubble_ex_o is 0, and fwd_sel_o holds its value.
  - If ex_is_mc_i=1 and mc_done_i=1 in the same cycle, there is no stall.
- Priority: flush_i > multi-cycle hold > load-use > normal.
  - flush_i: all stall and bubble outputs are 0, fwd_sel_o loads 00, and the FSM goes to IDLE.
  - Load-use detection is suppressed while the multi-cycle hold is active.

## Timing
- fwd_sel_o is registered and updates on the rising edge when EX is not held. Its value is valid for the EX instruction in the cycle after the ID decision.
- stall_*_o and bubble_ex_o are combinational from the inputs and FSM state, with zero-cycle latency.
- Reset values: fwd_sel_o=0, FSM=IDLE, both counters 0, and therefore all stall and bubble outputs 0.
- Reset asserted mid-MC_WAIT returns the FSM to IDLE immediately, with no pending state retained.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_lu_cnt_o increments in each load-use bubble cycle.
  - perf_mc_cnt_o increments in each multi-cycle stall cycle.
  - Both counters saturate at all-ones and are not cleared by flush_i.
- HAZARD_PERF_EN undefined: no counter flops; both ports are tied to 0.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_e: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - hz_state_e: IDLE, MC_WAIT.
- Sub-module fwd_match is the per-source comparator. It takes rs, used, valid and the EX/MEM destination fields and returns fwd_sel_e plus a load-hit flag. It is instantiated NSRC times in a generate loop.

## Test plan
- ID rs1=5; EX rd=5, wren=1, not a load -> no stall; the next cycle fwd_sel_o[1:0]=01.
- ID rs2=7; EX rd=7 load -> stall_if_o, stall_id_o, bubble_ex_o =1 for one cycle; the next cycle fwd_sel_o[3:2]=10, no stall; perf_lu_cnt_o=1 with HAZARD_PERF_EN.
- ID rs1=0; EX rd=0, wren=1 -> fwd_sel_o=00, no stall.
- ex_is_mc_i=1 with mc_done_i at cycle 4 -> stall_if_o, stall_id_o, stall_ex_o =1 for exactly 4 cycles; fwd_sel_o held; perf_mc_cnt_o=4.
- Load-use hazard coincident with flush_i=1 -> no stall, no bubble, fwd_sel_o=00.
- rst_ni pulled low during MC_WAIT -> all outputs 0 asynchronously; FSM is IDLE after release.
